// File: rtl/perf_counter_multi.sv
// perf_counter_multi
//   Multi-section performance counter exposed as an Avalon-MM slave.
//   Software brackets code regions with GO/STOP writes. Each section keeps:
//     - total active time
//     - GO event count
//     - last and maximum interval length
//     - sticky overflow flags
//   A global block provides CLEAR, freeze and identification registers.
//
// Ports
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   address    in   word address: [ADDR_WIDTH-1:3] block, [2:0] offset
//   read       in   one-cycle read strobe (no waitrequest)
//   write      in   one-cycle write strobe (no waitrequest)
//   writedata  in   32-bit write data
//   readdata   out  registered read data, valid one cycle after read
//
// Section register map (offset: read / write)
//   0: time[31:0], also latches time[TW-1:32] into hi_shadow / STOP
//   1: hi_shadow                                             / GO
//   2: event count
//   3: last interval
//   4: max interval
//   5: {evt_ovf, time_ovf, running}
//
// Global block (block index NUM_SECTIONS) register map
//   0: write {freeze, clear}; read {freeze, 0}
//   1: NUM_SECTIONS
//   2: TIME_WIDTH
module perf_counter_multi #(
  parameter int NUM_SECTIONS = 4,
  parameter int TIME_WIDTH   = 64,
  parameter int EVT_WIDTH    = 32,
  parameter int SATURATE     = 0,
  localparam int ADDR_WIDTH  = $clog2(NUM_SECTIONS + 1) + 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata
);

  localparam int BLK_W = ADDR_WIDTH - 3;

  logic [BLK_W-1:0] blk;
  logic [2:0]       off;
  assign blk = address[ADDR_WIDTH-1:3];
  assign off = address[2:0];

  // Only bits [1:0] of writedata carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:2];

  logic glb_wr;
  logic clear;
  logic freeze_q, freeze_d;

  assign glb_wr = write && (int'(blk) == NUM_SECTIONS) && (off == 3'd0);
  assign clear  = glb_wr & writedata[0];

  always_comb begin
    freeze_d = glb_wr ? writedata[1] : freeze_q;
  end

  // Per-section values gathered for the read mux.
  logic [31:0]          time_lo_rd [NUM_SECTIONS];
  logic [31:0]          hi_rd      [NUM_SECTIONS];
  logic [EVT_WIDTH-1:0] evt_rd     [NUM_SECTIONS];
  logic [31:0]          last_rd    [NUM_SECTIONS];
  logic [31:0]          max_rd     [NUM_SECTIONS];
  logic [2:0]           stat_rd    [NUM_SECTIONS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sec
      logic [TIME_WIDTH-1:0] time_q, time_d;
      logic [EVT_WIDTH-1:0]  evt_q, evt_d;
      logic [31:0]           ival_q, ival_d, ival_now;
      logic [31:0]           last_q, last_d, max_q, max_d, hi_q, hi_d;
      logic                  run_q, run_d, tovf_q, tovf_d, eovf_q, eovf_d;
      logic                  sel, go, stop, inc;

      assign sel  = (int'(blk) == gi);
      assign go   = write & sel & (off == 3'd1);
      assign stop = write & sel & (off == 3'd0);
      // Counting uses the pre-edge running/freeze state, so the STOP edge
      // still counts and the GO edge does not.
      assign inc  = run_q & ~freeze_q;

      always_comb begin
        time_d   = time_q;
        evt_d    = evt_q;
        ival_d   = ival_q;
        ival_now = ival_q;
        last_d   = last_q;
        max_d    = max_q;
        hi_d     = hi_q;
        run_d    = run_q;
        tovf_d   = tovf_q;
        eovf_d   = eovf_q;

        if (inc) begin
          if (SATURATE != 0) begin
            if (!(&time_q)) time_d = time_q + TIME_WIDTH'(1);
            if (&time_d) tovf_d = 1'b1;
          end else begin
            time_d = time_q + TIME_WIDTH'(1);
            if (&time_q) tovf_d = 1'b1;
          end
          // The interval always saturates regardless of SATURATE.
          if (!(&ival_q)) ival_now = ival_q + 32'd1;
        end
        ival_d = ival_now;

        if (go) begin
          if (!freeze_q) begin
            if (SATURATE != 0) begin
              if (!(&evt_q)) evt_d = evt_q + EVT_WIDTH'(1);
              if (&evt_d) eovf_d = 1'b1;
            end else begin
              evt_d = evt_q + EVT_WIDTH'(1);
              if (&evt_q) eovf_d = 1'b1;
            end
          end
          // A GO while already running only counts as an event.
          if (!run_q) begin
            run_d  = 1'b1;
            ival_d = '0;
          end
        end

        // The captured interval includes this edge's increment.
        if (stop && run_q) begin
          run_d  = 1'b0;
          last_d = ival_now;
          if (ival_now > max_q) max_d = ival_now;
        end

        if (read && sel && (off == 3'd0)) hi_d = 32'(time_q[TIME_WIDTH-1:32]);

        if (clear) begin
          time_d = '0;
          evt_d  = '0;
          ival_d = '0;
          last_d = '0;
          max_d  = '0;
          hi_d   = '0;
          run_d  = 1'b0;
          tovf_d = 1'b0;
          eovf_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          time_q <= '0;
          evt_q  <= '0;
          ival_q <= '0;
          last_q <= '0;
          max_q  <= '0;
          hi_q   <= '0;
          run_q  <= 1'b0;
          tovf_q <= 1'b0;
          eovf_q <= 1'b0;
        end else begin
          time_q <= time_d;
          evt_q  <= evt_d;
          ival_q <= ival_d;
          last_q <= last_d;
          max_q  <= max_d;
          hi_q   <= hi_d;
          run_q  <= run_d;
          tovf_q <= tovf_d;
          eovf_q <= eovf_d;
        end
      end

      assign time_lo_rd[gi] = time_q[31:0];
      assign hi_rd[gi]      = hi_q;
      assign evt_rd[gi]     = evt_q;
      assign last_rd[gi]    = last_q;
      assign max_rd[gi]     = max_q;
      assign stat_rd[gi]    = {eovf_q, tovf_q, run_q};
    end
  endgenerate

  logic [31:0] rd_val;
  logic [31:0] readdata_q, readdata_d;

  always_comb begin
    rd_val = '0;
    if (int'(blk) == NUM_SECTIONS) begin
      case (off)
        3'd0:    rd_val = {30'b0, freeze_q, 1'b0};
        3'd1:    rd_val = 32'(NUM_SECTIONS);
        3'd2:    rd_val = 32'(TIME_WIDTH);
        default: rd_val = '0;
      endcase
    end
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if (int'(blk) == i) begin
        case (off)
          3'd0:    rd_val = time_lo_rd[i];
          3'd1:    rd_val = hi_rd[i];
          3'd2:    rd_val = 32'(evt_rd[i]);
          3'd3:    rd_val = last_rd[i];
          3'd4:    rd_val = max_rd[i];
          3'd5:    rd_val = {29'b0, stat_rd[i]};
          default: rd_val = '0;
        endcase
      end
    end
    readdata_d = read ? rd_val : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freeze_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      freeze_q   <= freeze_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule
